// File: rtl/xeng_in_sched.sv
// rtl/xeng_in_sched.sv - X-engine input scheduler: frames upstream words into whole
// accumulation windows, zero-padding on underflow so vld never breaks mid-window.
module xeng_in_sched #(
  parameter int SERIAL_ACC_LEN_BITS = 7,
  parameter int N_ANTS              = 32,
  parameter int INPUT_WIDTH         = 64,
  parameter int MCNT_WIDTH          = 48
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   sync_in,
  input  logic                   src_valid,
  output logic                   src_ready,
  input  logic [INPUT_WIDTH-1:0] src_data,
  input  logic [MCNT_WIDTH-1:0]  src_mcnt,
  output logic [INPUT_WIDTH-1:0] din,
  output logic                   vld,
  output logic                   sync_out,
  output logic [MCNT_WIDTH-1:0]  mcnt,
  output logic [15:0]            win_cnt,
  output logic                   underflow,
  output logic [15:0]            err_cnt
);

  localparam int WIN_LEN = N_ANTS << SERIAL_ACC_LEN_BITS;
  localparam int CNT_W   = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_WAIT, S_RUN, S_PAD} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   first_q, first_d;
  logic                   sync_q, sync_d;
  logic                   s1_vld_q, s1_vld_d;
  logic                   s1_uf_q, s1_uf_d;
  logic [INPUT_WIDTH-1:0] s1_data_q, s1_data_d;
  logic [MCNT_WIDTH-1:0]  s1_mcnt_q, s1_mcnt_d;
  logic                   vld_q, uf_q;
  logic [INPUT_WIDTH-1:0] din_q;
  logic [MCNT_WIDTH-1:0]  mcnt_q;
  logic [15:0]            win_cnt_q, win_cnt_d;
  logic [15:0]            err_cnt_q, err_cnt_d;
  logic                   xfer;

  assign src_ready = (state_q == S_WAIT) || (state_q == S_RUN);
  assign xfer      = src_valid && src_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    sync_d    = 1'b0;
    s1_vld_d  = 1'b0;
    s1_uf_d   = 1'b0;
    s1_data_d = '0;
    s1_mcnt_d = s1_mcnt_q;
    win_cnt_d = win_cnt_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      S_IDLE: if (en) state_d = S_ARMED;
      S_ARMED: begin
        if (sync_in) begin
          first_d = 1'b1;
          state_d = S_WAIT;
        end else if (!en) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (xfer) begin
          s1_vld_d  = 1'b1;
          s1_data_d = src_data;
          s1_mcnt_d = src_mcnt;
          cnt_d     = CNT_W'(1);
          state_d   = S_RUN;
          sync_d    = first_q;
          first_d   = 1'b0;
        end else if (!en) begin
          first_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_RUN, S_PAD: begin
        // A missed word in RUN becomes the first zero of the pad, keeping vld contiguous.
        s1_vld_d  = 1'b1;
        s1_data_d = xfer ? src_data : '0;
        if (state_q == S_RUN && !xfer) begin
          s1_uf_d = 1'b1;
          if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          win_cnt_d = win_cnt_q + 16'd1;
          state_d   = en ? S_WAIT : S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!xfer) state_d = S_PAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      sync_q    <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_uf_q   <= 1'b0;
      s1_data_q <= '0;
      s1_mcnt_q <= '0;
      vld_q     <= 1'b0;
      uf_q      <= 1'b0;
      din_q     <= '0;
      mcnt_q    <= '0;
      win_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      sync_q    <= sync_d;
      s1_vld_q  <= s1_vld_d;
      s1_uf_q   <= s1_uf_d;
      s1_data_q <= s1_data_d;
      s1_mcnt_q <= s1_mcnt_d;
      vld_q     <= s1_vld_q;
      uf_q      <= s1_uf_q;
      din_q     <= s1_data_q;
      mcnt_q    <= s1_mcnt_q;
      win_cnt_q <= win_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign din       = din_q;
  assign vld       = vld_q;
  assign sync_out  = sync_q;
  assign mcnt      = mcnt_q;
  assign underflow = uf_q;
  assign win_cnt   = win_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_xeng_in_sched.sv
// tb/tb_xeng_in_sched.sv - directed bench for xeng_in_sched with a cycle model
// of window framing, padding and counters, checked every cycle.
module tb_xeng_in_sched;

  localparam int IW = 64;
  localparam int MW = 48;
  localparam int WL = 16;

  logic          clk, rst_n, en, sync_in, src_valid;
  logic          src_ready, vld, sync_out, underflow;
  logic [IW-1:0] src_data, din;
  logic [MW-1:0] src_mcnt, mcnt;
  logic [15:0]   win_cnt, err_cnt;

  xeng_in_sched #(
    .SERIAL_ACC_LEN_BITS(2), .N_ANTS(4), .INPUT_WIDTH(IW), .MCNT_WIDTH(MW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_in(sync_in),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data), .src_mcnt(src_mcnt),
    .din(din), .vld(vld), .sync_out(sync_out), .mcnt(mcnt),
    .win_cnt(win_cnt), .underflow(underflow), .err_cnt(err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int next_word;

  // model: 0 idle, 1 armed, 2 waiting for data, 3 streaming, 4 padding
  int          m_mode, m_pos, m_wins, m_errs;
  bit          m_first, m_sync;
  logic [MW-1:0] m_curm;
  bit          st1_v, st1_u, st2_v, st2_u;
  logic [IW-1:0] st1_d, st2_d;
  logic [MW-1:0] st1_m, st2_m;

  int vld_seen, uf_seen, sync_seen, zero_seen, gap, last_gap;
  int sync_cyc, d1_cyc, uf_cyc, first_zero_cyc;
  logic [MW-1:0] m17;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_wins = 0; m_errs = 0;
    m_first = 0; m_sync = 0; m_curm = '0;
    st1_v = 0; st1_u = 0; st1_d = '0; st1_m = '0;
    st2_v = 0; st2_u = 0; st2_d = '0; st2_m = '0;
  endtask

  task automatic model_step();
    bit e_v, e_u, ns, rdy, xf;
    logic [IW-1:0] e_d;
    e_v = 0; e_u = 0; ns = 0; e_d = '0;
    rdy = (m_mode == 2) || (m_mode == 3);
    xf  = rdy && src_valid;
    case (m_mode)
      0: if (en) m_mode = 1;
      1: begin
        if (sync_in) begin m_first = 1; m_mode = 2; end
        else if (!en) m_mode = 0;
      end
      2: begin
        if (xf) begin
          m_curm = src_mcnt; e_v = 1; e_d = src_data;
          m_pos = 1; ns = m_first; m_first = 0; m_mode = 3;
        end else if (!en) begin
          m_mode = 0; m_first = 0;
        end
      end
      default: begin
        e_v = 1;
        e_d = xf ? src_data : '0;
        if (m_mode == 3 && !xf) begin
          e_u = 1;
          if (m_errs != 65535) m_errs = m_errs + 1;
        end
        if (m_pos == WL - 1) begin
          m_pos = 0; m_wins = (m_wins + 1) % 65536; m_mode = en ? 2 : 0;
        end else begin
          m_pos = m_pos + 1; m_mode = xf ? 3 : 4;
        end
      end
    endcase
    st2_v = st1_v; st2_u = st1_u; st2_d = st1_d; st2_m = st1_m;
    st1_v = e_v; st1_u = e_u; st1_d = e_d; st1_m = m_curm;
    m_sync = ns;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) model_reset();
      chk("src_ready", {63'd0, src_ready}, {63'd0, (m_mode == 2 || m_mode == 3)});
      chk("vld", {63'd0, vld}, {63'd0, st2_v});
      chk("din", din, st2_d);
      chk("mcnt", {16'd0, mcnt}, {16'd0, st2_m});
      chk("underflow", {63'd0, underflow}, {63'd0, st2_u});
      chk("sync_out", {63'd0, sync_out}, {63'd0, m_sync});
      chk("win_cnt", {48'd0, win_cnt}, 64'(m_wins));
      chk("err_cnt", {48'd0, err_cnt}, 64'(m_errs));
      if (vld) begin
        if (gap > 0) last_gap = gap;
        gap = 0;
        vld_seen++;
        if (din == 0) begin
          if (zero_seen == 0) first_zero_cyc = cyc;
          zero_seen++;
        end
        if (din == 1) d1_cyc = cyc;
        if (din == 17) m17 = mcnt;
      end else begin
        gap++;
      end
      if (sync_out) begin sync_seen++; sync_cyc = cyc; end
      if (underflow) begin uf_seen++; uf_cyc = cyc; end
      if (rst_n) model_step();
    end
  end

  task automatic clear_mon();
    vld_seen = 0; uf_seen = 0; sync_seen = 0; zero_seen = 0; gap = 0; last_gap = 0;
    sync_cyc = -1; d1_cyc = -2; uf_cyc = -1; first_zero_cyc = -2; m17 = '0;
  endtask

  task automatic step();
    bit x;
    x = src_valid && src_ready;
    @(posedge clk);
    #1;
    if (x) begin
      next_word = next_word + 1;
      src_data  = IW'(next_word);
      src_mcnt  = MW'(100 + next_word - 1);
    end
  endtask

  task automatic run_until(input int n);
    for (int k = 0; k < 200 && next_word != n; k++) step();
    chk("run_until", 64'(next_word), 64'(n));
  endtask

  task automatic dut_reset();
    src_valid = 0; sync_in = 0;
    rst_n = 0;
    step(); step();
    rst_n = 1;
    next_word = 1; src_data = 1; src_mcnt = 100;
    clear_mon();
  endtask

  task automatic arm();
    en = 1;
    step();
    sync_in = 1;
    step();
    sync_in = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst_n = 0; en = 0; sync_in = 0; src_valid = 0; src_data = '0; src_mcnt = '0;
    next_word = 1;
    clear_mon();
    #1;
    idle(3);
    chk("reset_vld", {63'd0, vld}, 64'd0);
    chk("reset_ready", {63'd0, src_ready}, 64'd0);
    chk("reset_mcnt", {16'd0, mcnt}, 64'd0);

    // back-to-back windows
    dut_reset();
    arm();
    src_valid = 1;
    run_until(33);
    src_valid = 0;
    idle(5);
    chk("s1_vld_count", 64'(vld_seen), 64'd32);
    chk("s1_sync_lead", 64'(d1_cyc - sync_cyc), 64'd1);
    chk("s1_mcnt_w2", {16'd0, m17}, 64'd116);
    chk("s1_win_cnt", {48'd0, win_cnt}, 64'd2);

    // 3-cycle gap between windows
    dut_reset();
    arm();
    src_valid = 1;
    run_until(17);
    src_valid = 0;
    idle(3);
    src_valid = 1;
    run_until(33);
    src_valid = 0;
    idle(5);
    chk("s2_vld_count", 64'(vld_seen), 64'd32);
    chk("s2_gap", 64'(last_gap), 64'd3);
    chk("s2_underflow", 64'(uf_seen), 64'd0);

    // underflow at word 6
    dut_reset();
    arm();
    src_valid = 1;
    run_until(6);
    src_valid = 0;
    idle(20);
    chk("s3_vld_count", 64'(vld_seen), 64'd16);
    chk("s3_zero_words", 64'(zero_seen), 64'd11);
    chk("s3_uf_pulses", 64'(uf_seen), 64'd1);
    chk("s3_uf_align", 64'(uf_cyc), 64'(first_zero_cyc));
    chk("s3_err_cnt", {48'd0, err_cnt}, 64'd1);
    chk("s3_win_cnt", {48'd0, win_cnt}, 64'd1);

    // en falls mid-window
    dut_reset();
    arm();
    src_valid = 1;
    run_until(8);
    en = 0;
    idle(20);
    chk("s4_vld_count", 64'(vld_seen), 64'd16);
    chk("s4_no_more_xfer", 64'(next_word), 64'd17);
    chk("s4_ready_low", {63'd0, src_ready}, 64'd0);
    sync_seen = 0;
    sync_in = 1;
    step();
    sync_in = 0;
    idle(5);
    chk("s4_lone_sync", 64'(sync_seen), 64'd0);

    // async reset mid-window
    dut_reset();
    arm();
    src_valid = 1;
    run_until(10);
    rst_n = 0;
    #1;
    chk("s5_vld", {63'd0, vld}, 64'd0);
    chk("s5_din", din, 64'd0);
    chk("s5_ready", {63'd0, src_ready}, 64'd0);
    chk("s5_win_cnt", {48'd0, win_cnt}, 64'd0);
    step();
    rst_n = 1;
    clear_mon();
    idle(10);
    chk("s5_no_vld_unarmed", 64'(vld_seen), 64'd0);
    sync_in = 1;
    step();
    sync_in = 0;
    run_until(26);
    src_valid = 0;
    idle(5);
    chk("s5_rearm_vld", 64'(vld_seen), 64'd16);

    // counter saturation and wrap
    en = 0;
    dut_reset();
    force dut.err_cnt_q = 16'hFFFE;
    force dut.win_cnt_q = 16'hFFFE;
    m_errs = 65534;
    m_wins = 65534;
    step();
    release dut.err_cnt_q;
    release dut.win_cnt_q;
    step();
    arm();
    src_valid = 1;
    run_until(3);
    src_valid = 0;
    idle(20);
    chk("s6_err_ffff", {48'd0, err_cnt}, 64'hFFFF);
    chk("s6_win_ffff", {48'd0, win_cnt}, 64'hFFFF);
    src_valid = 1;
    run_until(5);
    src_valid = 0;
    idle(20);
    chk("s6_err_sat", {48'd0, err_cnt}, 64'hFFFF);
    chk("s6_win_wrap", {48'd0, win_cnt}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
